// File: rtl/amp_pwr_pkg.sv
// Shared types and constants for the amplifier power sequencer.
package amp_pwr_pkg;

  typedef enum logic [2:0] {
    STARTUP,
    SETTLE,
    RAMP,
    RUN,
    FAULT,
    LOCKOUT
  } pwr_state_t;

  localparam int GAIN_W = 12;
  localparam logic [GAIN_W-1:0] GAIN_MAX = 12'hFFF;

  // Default retry interval sets the nominal counter width; the top re-sizes
  // the counter from its actual parameters so overrides stay safe.
  localparam int RETRY_CYC_DEF = 2500000;
  localparam int CNT_W         = $clog2(RETRY_CYC_DEF + 1);

  // Largest of the three timed intervals, used to size the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/flt_filter.sv
// Synchronizer plus consecutive-low qualifier for an active-low async input.
// Emits a single-cycle pulse once the input has been low for FLT_FILT
// synchronized samples; it re-arms only after the input goes high again.
module flt_filter #(
  parameter int FLT_FILT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in_n,
  output logic o_pulse
);

  localparam int FW = $clog2(FLT_FILT + 1);
  localparam logic [FW-1:0] C_FILT    = FW'(FLT_FILT);
  localparam logic [FW-1:0] C_FILT_M1 = FW'(FLT_FILT - 1);

  logic [1:0]    r_sync;
  logic [FW-1:0] r_cnt;
  logic          w_low;

  assign w_low = ~r_sync[1];

  // Two-flop synchronizer; idles high so reset does not look like a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], i_in_n};
  end

  // Count consecutive low samples, saturate at the threshold, clear on high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (!w_low)        r_cnt <= '0;
    else if (r_cnt != C_FILT) r_cnt <= r_cnt + 1'b1;
  end

  // One-shot: fires on the sample that brings the count to the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_pulse <= 1'b0;
    else        o_pulse <= w_low && (r_cnt == C_FILT_M1);
  end

endmodule

// File: rtl/amp_pwr_seq.sv
// Class-D amplifier power sequencer: startup delay gated on EQ queue fill,
// settle-while-muted, soft-start gain ramp, and fault retry with lockout.
module amp_pwr_seq
  import amp_pwr_pkg::*;
#(
  parameter int STARTUP_CYC = 250000,
  parameter int SETTLE_CYC  = 5000,
  parameter int RETRY_CYC   = 2500000,
  parameter int FLT_FILT    = 4,
  parameter int RAMP_STEP   = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic              seq_low,
  input  logic              Flt_n,
  output logic              sht_dwn,
  output logic [GAIN_W-1:0] gain,
  output logic              mute,
  output logic [1:0]        flt_cnt,
  output logic              lockout
);

  localparam int CW = $clog2(max3(STARTUP_CYC, SETTLE_CYC, RETRY_CYC) + 1);
  localparam logic [CW-1:0] C_START_TC  = CW'(STARTUP_CYC - 1);
  localparam logic [CW-1:0] C_SETTLE_TC = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] C_RETRY_TC  = CW'(RETRY_CYC - 1);
  localparam logic [GAIN_W:0] C_STEP    = (GAIN_W+1)'(RAMP_STEP);
  localparam logic [GAIN_W:0] C_GMAX    = {1'b0, GAIN_MAX};

  pwr_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic             w_flt_q;
  logic [GAIN_W:0]  w_sum;
  logic             w_sat;
  logic             w_last_retry;
  logic [1:0]       w_flt_cnt_nxt;

  flt_filter #(
    .FLT_FILT (FLT_FILT)
  ) u_flt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_in_n  (Flt_n),
    .o_pulse (w_flt_q)
  );

  // Ramp arithmetic carries one extra bit so overflow past unity is clamped.
  assign w_sum         = {1'b0, gain} + C_STEP;
  assign w_sat         = (w_sum >= C_GMAX);
  assign w_last_retry  = (int'(flt_cnt) == MAX_RETRY);
  assign w_flt_cnt_nxt = (flt_cnt == 2'd3) ? 2'd3 : flt_cnt + 2'd1;

  // Sequencer FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STARTUP;
      r_cnt   <= '0;
      sht_dwn <= 1'b1;
      gain    <= '0;
      mute    <= 1'b1;
      flt_cnt <= 2'd0;
      lockout <= 1'b0;
    end else begin
      case (r_state)
        // Amp off; wait out the startup delay, then hold for queue fill.
        STARTUP: begin
          if (r_cnt == C_START_TC) begin
            if (seq_low) begin
              r_state <= SETTLE;
              r_cnt   <= '0;
              sht_dwn <= 1'b0;
              gain    <= '0;
              mute    <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Active states: a qualified fault preempts every other transition.
        SETTLE, RAMP, RUN: begin
          if (w_flt_q) begin
            r_state <= w_last_retry ? LOCKOUT : FAULT;
            lockout <= w_last_retry;
            r_cnt   <= '0;
            sht_dwn <= 1'b1;
            gain    <= '0;
            mute    <= 1'b1;
            flt_cnt <= w_flt_cnt_nxt;
          end else if (r_state == SETTLE) begin
            if (r_cnt == C_SETTLE_TC) begin
              r_state <= RAMP;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_state == RAMP) begin
            if (vld) begin
              if (w_sat) begin
                gain    <= GAIN_MAX;
                mute    <= 1'b0;
                r_state <= RUN;
              end else begin
                gain <= w_sum[GAIN_W-1:0];
              end
            end
          end
        end

        // Shut down for the retry interval; a repeat fault restarts it.
        FAULT: begin
          if (w_flt_q) begin
            r_cnt <= '0;
          end else if (r_cnt == C_RETRY_TC) begin
            r_state <= STARTUP;
            r_cnt   <= C_START_TC;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Terminal: only reset leaves this state.
        LOCKOUT: begin
          sht_dwn <= 1'b1;
          gain    <= '0;
          mute    <= 1'b1;
          lockout <= 1'b1;
        end

        default: begin
          r_state <= STARTUP;
          r_cnt   <= '0;
          sht_dwn <= 1'b1;
          gain    <= '0;
          mute    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Scoreboard bench for amp_pwr_seq with shortened timing parameters.
// Expected output snapshots are queued with the sample index at which they
// must appear; a negedge monitor pops and compares them.
module tb_amp_pwr_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic        seq_low;
  logic        Flt_n;
  logic        sht_dwn;
  logic [11:0] gain;
  logic        mute;
  logic [1:0]  flt_cnt;
  logic        lockout;

  amp_pwr_seq #(
    .STARTUP_CYC (20),
    .SETTLE_CYC  (5),
    .RETRY_CYC   (30),
    .FLT_FILT    (4),
    .RAMP_STEP   (1024),
    .MAX_RETRY   (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (vld),
    .seq_low (seq_low),
    .Flt_n   (Flt_n),
    .sht_dwn (sht_dwn),
    .gain    (gain),
    .mute    (mute),
    .flt_cnt (flt_cnt),
    .lockout (lockout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    logic [16:0] v;   // {sht_dwn, mute, lockout, flt_cnt, gain}
  } exp_t;

  exp_t sb[$];
  int   ncyc   = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got {sd,mu,lo,fc,gain}=%h want %h (sample %0d)", tag, obs, exp_v, ncyc);
  endtask

  // Monitor: one sample per negedge, compare every entry due now.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    while (sb.size() > 0 && sb[0].cyc <= ncyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < ncyc) chk({e.tag, "_missed"}, 17'h1FFFF, e.v);
      else              chk(e.tag, {sht_dwn, mute, lockout, flt_cnt, gain}, e.v);
    end
  end

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int off, input string tag, input logic sd,
                      input logic [11:0] g, input logic [1:0] fc, input logic lo);
    exp_t e;
    logic mu;
    mu    = sd || (g != 12'hFFF);
    e.cyc = ncyc + off;
    e.tag = tag;
    e.v   = {sd, mu, lo, fc, g};
    sb.push_back(e);
  endtask

  // Reset, release, and drive startup; seq_at=0 means queues full from start.
  task automatic power_up(input int seq_at, input bit full);
    int t_en, e1, last;
    rst_n = 1'b0; seq_low = 1'b0; vld = 1'b0; Flt_n = 1'b1;
    nclk(); nclk();
    push(1, "rst", 1'b1, 12'h000, 2'd0, 1'b0);
    nclk();
    t_en = (seq_at == 0) ? 20 : seq_at + 1;
    e1 = t_en + 6;
    while (e1 % 4 != 1) e1++;
    last = full ? e1 + 13 : e1 + 4;
    push(1,         "start",   1'b1, 12'h000, 2'd0, 1'b0);
    push(t_en - 1,  "pre_en",  1'b1, 12'h000, 2'd0, 1'b0);
    push(t_en,      "en",      1'b0, 12'h000, 2'd0, 1'b0);
    push(t_en + 5,  "settled", 1'b0, 12'h000, 2'd0, 1'b0);
    push(e1 - 1,    "ramp0",   1'b0, 12'h000, 2'd0, 1'b0);
    push(e1,        "g1024",   1'b0, 12'd1024, 2'd0, 1'b0);
    if (full) begin
      push(e1 + 3,  "g_hold",  1'b0, 12'd1024, 2'd0, 1'b0);
      push(e1 + 4,  "g2048",   1'b0, 12'd2048, 2'd0, 1'b0);
      push(e1 + 8,  "g3072",   1'b0, 12'd3072, 2'd0, 1'b0);
      push(e1 + 12, "g_unity", 1'b0, 12'hFFF, 2'd0, 1'b0);
      push(e1 + 13, "run",     1'b0, 12'hFFF, 2'd0, 1'b0);
    end else begin
      push(e1 + 4,  "g2048",   1'b0, 12'd2048, 2'd0, 1'b0);
    end
    for (int j = 0; j < last; j++) begin
      rst_n   = 1'b1;
      seq_low = (seq_at == 0) || (j >= seq_at);
      vld     = (j > 0) && (j % 4 == 0);
      Flt_n   = 1'b1;
      nclk();
    end
    vld = 1'b0;
  endtask

  // Four-sample Flt_n low pulse; seq_hi_at=0 keeps queues full throughout.
  task automatic fault_seq(input logic [1:0] pre_fc, input logic [1:0] post_fc,
                           input bit lock, input int seq_hi_at, input logic [11:0] pre_g);
    int last;
    push(6, "pre_flt", 1'b0, pre_g, pre_fc, 1'b0);
    push(7, lock ? "lockout" : "flt", 1'b1, 12'h000, post_fc, lock);
    if (lock) begin
      push(1007, "lock_hold", 1'b1, 12'h000, post_fc, 1'b1);
      last = 1008;
    end else if (seq_hi_at == 0) begin
      push(37, "retry_end", 1'b1, 12'h000, post_fc, 1'b0);
      push(38, "reen",      1'b0, 12'h000, post_fc, 1'b0);
      last = 38;
    end else begin
      push(37,            "retry_end", 1'b1, 12'h000, post_fc, 1'b0);
      push(seq_hi_at,     "wait_seq",  1'b1, 12'h000, post_fc, 1'b0);
      push(seq_hi_at + 1, "reen",      1'b0, 12'h000, post_fc, 1'b0);
      last = seq_hi_at + 1;
    end
    for (int j = 0; j < last; j++) begin
      Flt_n   = (j >= 4);
      seq_low = (seq_hi_at == 0) || (j >= seq_hi_at);
      vld     = lock && (j % 4 == 0);
      nclk();
    end
    vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; vld = 1'b0; seq_low = 1'b0; Flt_n = 1'b1;

    // Power-up with queues full.
    power_up(0, 1'b1);

    // Three-sample glitch in RUN must be rejected.
    push(7,  "glitch_a", 1'b0, 12'hFFF, 2'd0, 1'b0);
    push(11, "glitch_b", 1'b0, 12'hFFF, 2'd0, 1'b0);
    for (int j = 0; j < 12; j++) begin
      Flt_n = (j >= 3);
      nclk();
    end

    // Qualified fault from RUN, retry with queues empty until later.
    fault_seq(2'd0, 2'd1, 1'b0, 45, 12'hFFF);
    // Further faults land while settling/ramping.
    fault_seq(2'd1, 2'd2, 1'b0, 0, 12'h000);
    fault_seq(2'd2, 2'd3, 1'b0, 0, 12'h000);
    fault_seq(2'd3, 2'd3, 1'b1, 0, 12'h000);

    // Async reset mid-ramp at gain 2048, between clock edges.
    power_up(0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push(1, "async_rst", 1'b1, 12'h000, 2'd0, 1'b0);
    nclk();

    // Queue gating: seq_low held low until sample 100.
    power_up(100, 1'b1);

    nclk(); nclk();
    if (sb.size() != 0) chk("sb_drain", 17'(sb.size()), 17'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
